// File: rtl/regfile_sb.sv
// Integer register file with two async read ports, one sync write port, a pending
// scoreboard bit per entry and a one-entry-per-cycle clear sweep. Optional macro: RF_BYPASS_EN.
module regfile_sb #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              WE,
   input  logic [ADDR_W-1:0] WDA,
   input  logic [DATA_W-1:0] WD,
   input  logic [ADDR_W-1:0] RDA1,
   input  logic [ADDR_W-1:0] RDA2,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   input  logic              ISSUE,
   input  logic [ADDR_W-1:0] IDA,
   output logic              PEND1,
   output logic              PEND2,
   input  logic              CLR,
   output logic              BUSY
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {IDLE, SWEEP} clearState_t;

   logic [DATA_W-1:0] regArray [DEPTH];
   logic [DEPTH-1:0]  pend;
   clearState_t       state;
   logic [ADDR_W-1:0] ptr;
   logic              writeOk;
   logic              issueOk;

   // Writes and issues are only honoured while idle and never touch a hardwired zero entry.
   assign writeOk = WE && (state == IDLE) && !((ZERO_REG != 0) && (WDA == '0));
   assign issueOk = ISSUE && (state == IDLE) && !((ZERO_REG != 0) && (IDA == '0));
   assign BUSY    = (state == SWEEP);

   // Storage, scoreboard and clear sequencer; the issue set is placed last so it wins a same-address write.
   always_ff @(posedge CLK) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regArray[i] <= '0;
         end
         pend  <= '0;
         state <= IDLE;
         ptr   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (writeOk) begin
                  regArray[WDA] <= WD;
                  pend[WDA]     <= 1'b0;
               end
               if (issueOk) begin
                  pend[IDA] <= 1'b1;
               end
               if (CLR) begin
                  state <= SWEEP;
                  ptr   <= '0;
               end
            end
            SWEEP: begin
               regArray[ptr] <= '0;
               pend[ptr]     <= 1'b0;
               ptr           <= ptr + 1'b1;
               if (ptr == ADDR_W'(DEPTH - 1)) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read port 1, with optional same-cycle forwarding of the write in flight.
   always_comb begin
      RD1   = regArray[RDA1];
      PEND1 = pend[RDA1];
`ifdef RF_BYPASS_EN
      if (writeOk && (RDA1 == WDA)) begin
         RD1   = WD;
         PEND1 = issueOk && (IDA == WDA);
      end
`endif
      if ((ZERO_REG != 0) && (RDA1 == '0)) begin
         RD1   = '0;
         PEND1 = 1'b0;
      end
   end

   // Read port 2, identical behaviour to port 1.
   always_comb begin
      RD2   = regArray[RDA2];
      PEND2 = pend[RDA2];
`ifdef RF_BYPASS_EN
      if (writeOk && (RDA2 == WDA)) begin
         RD2   = WD;
         PEND2 = issueOk && (IDA == WDA);
      end
`endif
      if ((ZERO_REG != 0) && (RDA2 == '0)) begin
         RD2   = '0;
         PEND2 = 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, hand-written sweep sequences
// and randomized traffic checked against a behavioural register-file model.
module tb_regfile_sb;

   logic        CLK = 1'b0;
   logic        reset;
   logic        WE, ISSUE, CLR;
   logic [4:0]  WDA, IDA, RDA1, RDA2;
   logic [31:0] WD;
   logic [31:0] RD1, RD2;
   logic        PEND1, PEND2, BUSY;

   int checks = 0;
   int errors = 0;
   logic lastBusy;

   logic [31:0] mMem [32];
   bit          mPend [32];
   int          mSweep;

   typedef struct {
      logic        we;
      logic [4:0]  wda;
      logic [31:0] wd;
      logic        issue;
      logic [4:0]  ida;
      logic [4:0]  rda1;
      logic [31:0] expRd1;
      logic        expPend1;
   } vector_t;

   vector_t vectors [10];

   regfile_sb dut (
      .CLK(CLK), .reset(reset), .WE(WE), .WDA(WDA), .WD(WD),
      .RDA1(RDA1), .RDA2(RDA2), .RD1(RD1), .RD2(RD2),
      .ISSUE(ISSUE), .IDA(IDA), .PEND1(PEND1), .PEND2(PEND2),
      .CLR(CLR), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] expRead(input logic [4:0] addr);
      if (addr == 5'd0) return 32'd0;
`ifdef RF_BYPASS_EN
      if (WE && mSweep < 0 && addr == WDA && WDA != 5'd0) return WD;
`endif
      return mMem[addr];
   endfunction

   function automatic logic expPend(input logic [4:0] addr);
      if (addr == 5'd0) return 1'b0;
`ifdef RF_BYPASS_EN
      if (WE && mSweep < 0 && addr == WDA && WDA != 5'd0) return ISSUE && (IDA == WDA);
`endif
      return mPend[addr];
   endfunction

   // Reference behaviour of one rising edge, from the register-file rules.
   task automatic modelEdge();
      if (reset) begin
         foreach (mMem[i]) begin
            mMem[i]  = 32'd0;
            mPend[i] = 1'b0;
         end
         mSweep = -1;
      end else if (mSweep >= 0) begin
         mMem[mSweep]  = 32'd0;
         mPend[mSweep] = 1'b0;
         mSweep++;
         if (mSweep == 32) mSweep = -1;
      end else begin
         if (WE && WDA != 5'd0) begin
            mMem[WDA]  = WD;
            mPend[WDA] = 1'b0;
         end
         if (ISSUE && IDA != 5'd0) mPend[IDA] = 1'b1;
         if (CLR) mSweep = 0;
      end
   endtask

   task automatic checkOutput();
      checkVal("rd1", RD1, expRead(RDA1));
      checkVal("rd2", RD2, expRead(RDA2));
      checkVal("pend1", 32'(PEND1), 32'(expPend(RDA1)));
      checkVal("pend2", 32'(PEND2), 32'(expPend(RDA2)));
      checkVal("busy", 32'(BUSY), 32'(mSweep >= 0));
      lastBusy = BUSY;
   endtask

   // One clock cycle: drive inputs, check at the falling edge, advance the model at the rising edge.
   task automatic applyStimulus(input logic we, input logic [4:0] wda, input logic [31:0] wd,
                                input logic issue, input logic [4:0] ida,
                                input logic [4:0] rda1, input logic [4:0] rda2,
                                input logic clr, input logic rst);
      WE = we; WDA = wda; WD = wd; ISSUE = issue; IDA = ida;
      RDA1 = rda1; RDA2 = rda2; CLR = clr; reset = rst;
      @(negedge CLK);
      checkOutput();
      @(posedge CLK);
      modelEdge();
      #1;
   endtask

   task automatic readAll();
      for (int i = 0; i < 32; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0);
      end
   endtask

   task automatic countSweep(input int abortAt, output int busyCount);
      busyCount = 0;
      for (int c = 0; c < 100; c++) begin
         if (c == 4) applyStimulus(1, 5'd31, 32'hBAD0BAD0, 0, 0, 5'd31, 5'(c), 1, 0);
         else        applyStimulus(0, 0, 0, 0, 0, 5'(c % 32), 5'd31, 0, (c == abortAt));
         if (lastBusy) busyCount++;
         else break;
      end
   endtask

   initial begin
      int busyCount;
      WE = 0; WDA = 0; WD = 0; ISSUE = 0; IDA = 0; RDA1 = 0; RDA2 = 0; CLR = 0; reset = 1;
      repeat (2) begin
         @(posedge CLK);
         modelEdge();
      end
      #1;

      $display("[TB] reset state");
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
      readAll();

      $display("[TB] directed vectors");
      vectors[0] = '{1, 5'd7, 32'hDEADBEEF, 0, 5'd0, 5'd1, 32'h0, 0};
      vectors[1] = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd7, 32'hDEADBEEF, 0};
      vectors[2] = '{1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 5'd7, 32'hDEADBEEF, 0};
      vectors[3] = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd0, 32'h0, 0};
      vectors[4] = '{0, 5'd0, 32'h0,        1, 5'd3, 5'd7, 32'hDEADBEEF, 0};
      vectors[5] = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd3, 32'h0, 1};
      vectors[6] = '{1, 5'd3, 32'h11112222, 0, 5'd0, 5'd7, 32'hDEADBEEF, 0};
      vectors[7] = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd3, 32'h11112222, 0};
      vectors[8] = '{1, 5'd3, 32'h33334444, 1, 5'd3, 5'd7, 32'hDEADBEEF, 0};
      vectors[9] = '{0, 5'd0, 32'h0,        0, 5'd0, 5'd3, 32'h33334444, 1};
      for (int v = 0; v < 10; v++) begin
         WE = vectors[v].we; WDA = vectors[v].wda; WD = vectors[v].wd;
         ISSUE = vectors[v].issue; IDA = vectors[v].ida;
         RDA1 = vectors[v].rda1; RDA2 = 5'd0; CLR = 0; reset = 0;
         @(negedge CLK);
         checkVal($sformatf("vec%0d_rd1", v), RD1, vectors[v].expRd1);
         checkVal($sformatf("vec%0d_pend1", v), 32'(PEND1), 32'(vectors[v].expPend1));
         checkOutput();
         @(posedge CLK);
         modelEdge();
         #1;
      end
`ifdef RF_BYPASS_EN
      applyStimulus(1, 5'd9, 32'hCAFEF00D, 0, 0, 5'd9, 5'd0, 0, 0);
`endif

      $display("[TB] full sweep");
      for (int i = 1; i < 32; i++) begin
         applyStimulus(1, 5'(i), 32'h10000001 + 32'(i) * 3, 0, 0, 5'(i), 5'd0, 0, 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 5'd31, 5'd1, 1, 0);
      countSweep(-1, busyCount);
      checkVal("sweep_len", 32'(busyCount), 32'd32);
      readAll();

      $display("[TB] reset mid-sweep");
      for (int i = 1; i < 32; i += 3) begin
         applyStimulus(1, 5'(i), 32'hA5A50000 + 32'(i), 1, 5'(i), 5'd0, 5'd0, 0, 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 5'd1, 5'd4, 1, 0);
      countSweep(9, busyCount);
      checkVal("abort_len", 32'(busyCount), 32'd10);
      readAll();
      applyStimulus(0, 0, 0, 0, 0, 5'd0, 5'd0, 1, 0);
      countSweep(-1, busyCount);
      checkVal("resweep_len", 32'(busyCount), 32'd32);

      $display("[TB] random traffic");
      for (int n = 0; n < 600; n++) begin
         applyStimulus(1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                       1'($urandom_range(0, 2) == 0), 5'($urandom),
                       5'($urandom), 5'($urandom),
                       1'($urandom_range(0, 60) == 0), 1'($urandom_range(0, 250) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
